// File: rtl/instruction_sequencer.sv
// Sequencing back end of the control unit: instruction register, micro-step
// counter, latched ALU flags and the datapath cycle enable (incl. single-step).
module instruction_sequencer #(
  parameter  int INSTRUCTION_WIDTH = 16,
  parameter  int INSTRUCTION_STEPS = 32,
  localparam int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [INSTRUCTION_WIDTH-1:0] i_bus,
  input  logic                         i_ii,
  input  logic                         i_el,
  input  logic                         i_adv,
  input  logic                         i_hlt,
  input  logic                         i_alu_zero,
  input  logic                         i_alu_carry,
  input  logic                         i_alu_odd,
  input  logic                         i_single_step,
  input  logic                         i_step_pulse,
  input  logic                         i_resume,
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  output logic [STEP_WIDTH-1:0]        o_step,
  output logic                         o_zero,
  output logic                         o_carry,
  output logic                         o_odd,
  output logic                         o_cycle_en,
  output logic                         o_halted,
  output logic                         o_fault
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [STEP_WIDTH-1:0] STEP_MAX = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  state_t                state, state_next;
  logic [STEP_WIDTH-1:0] step_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // HLT outranks ADV; a step counter hitting max without either is a runaway
  always_comb begin
    state_next = state;
    step_next  = o_step;
    case (state)
      ST_RUN: begin
        if (o_cycle_en) begin
          if (i_hlt) begin
            state_next = ST_HALTED;
          end else if (i_adv) begin
            step_next = '0;
          end else if (o_step == STEP_MAX) begin
            state_next = ST_FAULT;
          end else begin
            step_next = o_step + STEP_WIDTH'(1);
          end
        end
      end
      ST_HALTED: begin
        if (i_resume) begin
          state_next = ST_RUN;
          step_next  = '0;
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  always_comb begin
    o_cycle_en = (state == ST_RUN) & (~i_single_step | i_step_pulse);
  end

  // Registered decoder-facing state; instruction and flags load only on enabled cycles
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_step        <= '0;
      o_instruction <= '0;
      o_zero        <= 1'b0;
      o_carry       <= 1'b0;
      o_odd         <= 1'b0;
      o_halted      <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      o_step   <= step_next;
      o_halted <= (state_next == ST_HALTED);
      o_fault  <= (state_next == ST_FAULT);
      if (o_cycle_en && i_ii) begin
        o_instruction <= i_bus;
      end
      if (o_cycle_en && i_el) begin
        o_zero  <= i_alu_zero;
        o_carry <= i_alu_carry;
        o_odd   <= i_alu_odd;
      end
    end
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Sequencing back end of the control unit. It holds the instruction register, the step counter and the latched ALU flags that feed the combinational instruction decoder. It consumes the decoder's control bits (II, EL, ADV, HLT) and closes the loop: it advances or restarts the micro-step and halts or faults the machine. It also generates the datapath cycle enable, including a debug single-step mode.

## Interface
- INSTRUCTION_WIDTH, 16, width of instruction register and bus input
- INSTRUCTION_STEPS, 32, micro-steps per instruction; STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
- i_clk  in  1  system clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_bus  in  INSTRUCTION_WIDTH  data bus (instruction fetch source)
- i_ii  in  1  decoder c_II: load instruction register
- i_el  in  1  decoder c_EL: latch ALU flags
- i_adv  in  1  decoder c_ADV: last step of instruction
- i_hlt  in  1  decoder c_HLT: halt request
- i_alu_zero, i_alu_carry, i_alu_odd  in  1 each  live ALU flags
- i_single_step  in  1  1 = debug mode, steps only on i_step_pulse
- i_step_pulse  in  1  one-cycle request for one step (debug mode)
- i_resume  in  1  one-cycle request to leave HALTED
- o_instruction  out  INSTRUCTION_WIDTH  registered instruction to decoder
- o_step  out  STEP_WIDTH  registered micro-step to decoder
- o_zero, o_carry, o_odd  out  1 each  registered flags to decoder
- o_cycle_en  out  1  combinational; datapath registers write only when 1
- o_halted  out  1  registered, state == HALTED
- o_fault  out  1  registered, state == FAULT

## Operation
- States: RUN, HALTED, FAULT.
- o_cycle_en = (state==RUN) & (~i_single_step | i_step_pulse). All control-bit inputs are ignored on cycles with o_cycle_en=0.
- Enabled RUN cycle, priority high to low:
  - i_hlt: go to HALTED, step held.
  - i_adv: step <= 0.
  - step == INSTRUCTION_STEPS-1: go to FAULT, step held at max (runaway instruction, no ADV).
  - otherwise: step <= step+1.
- i_ii on an enabled cycle: o_instruction <= i_bus. This is independent of the step priority above.
- i_el on an enabled cycle: flags <= ALU flags. It is independent of the priority and is also honoured on the HLT cycle.
- HALTED: outputs frozen. i_resume moves to RUN with step <= 0 (the halt instruction never issues ADV). i_single_step has no effect on resume.
- FAULT: outputs frozen. Only i_reset exits. i_resume is ignored.
- i_resume while in RUN: ignored.
- Reset dominates everything. Reset values: step 0, o_instruction 0 (NOP), all flags 0, o_halted 0, o_fault 0, state RUN. o_cycle_en is therefore 1 in the cycle after reset (when i_single_step=0).

## Timing
- Decoder is combinational: the control word for o_step=n is valid in the same cycle. Updates land at the next rising edge.
- Fetch: the instruction is latched at the end of step 1 and is visible in o_instruction from step 2 onward.
- ADV asserted during step k: o_step=0 in the next enabled cycle. The shortest instruction is 3 cycles (steps 0,1,2).
- HLT during step k: o_halted=1 and o_cycle_en=0 from the next cycle; o_step stays k.
- i_resume while HALTED: o_step=0, o_halted=0 and o_cycle_en=1 in the next cycle.
- Runaway: enabled step at INSTRUCTION_STEPS-1 without ADV or HLT gives o_fault=1 in the next cycle.
- Single-step: exactly one step per i_step_pulse cycle. A pulse held high for N cycles gives N steps.
- No combinational path from i_bus or the ALU flags to any registered output.

## Test plan
- Reset, run with i_bus=0x0001 during step 1, ADV at step 3 -> o_step 0,1,2,3,0; o_instruction=0x0001 from the cycle o_step=2.
- HLT at step 2, wait 10 cycles, pulse i_resume -> o_halted=1 and o_cycle_en=0 for those 10 cycles with o_step=2; next cycle after resume o_step=0, o_halted=0.
- Never assert ADV/HLT -> o_step climbs to 31, then o_fault=1, o_cycle_en=0, o_step stays 31; i_resume ignored; i_reset clears all outputs to 0.
- i_single_step=1, i_step_pulse every 5th cycle -> o_step increments exactly once per pulse; i_ii with i_bus=0x00AB on a non-pulse cycle does not change o_instruction.
- EL with zero=1, carry=0, odd=1 -> o_zero=1, o_carry=0, o_odd=1 next cycle; EL with all flags 0 while HALTED -> flags unchanged.
- HLT and ADV in the same cycle -> HALTED wins, o_step held. Reset asserted at step 3 mid-instruction -> next cycle o_step=0, o_instruction=0, flags 0.
